// File: rtl/mem_port_arbiter.sv
// Merges N requester ports onto one memory bus; an in-order tag FIFO of port ids
// routes each in-order memory response back to the port that issued it.
module mem_port_arbiter #(
  parameter int unsigned XLEN            = 32,
  parameter int unsigned N_PORTS         = 2,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned ARB_MODE        = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_PORTS-1:0]              up_req_valid,
  output logic [N_PORTS-1:0]              up_req_ready,
  input  logic [N_PORTS-1:0]              up_req_we,
  input  logic [N_PORTS*XLEN-1:0]         up_req_addr,
  input  logic [N_PORTS*XLEN-1:0]         up_req_wdata,
  input  logic [N_PORTS*2-1:0]            up_req_len,
  output logic [N_PORTS-1:0]              up_resp_valid,
  output logic [XLEN-1:0]                 up_resp_data,
  output logic                            mem_req_valid,
  input  logic                            mem_req_ready,
  output logic                            mem_req_we,
  output logic [XLEN-1:0]                 mem_req_addr,
  output logic [XLEN-1:0]                 mem_req_wdata,
  output logic [1:0]                      mem_req_len,
  input  logic                            mem_resp_valid,
  input  logic [XLEN-1:0]                 mem_resp_data,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
  output logic                            err_orphan
);

  localparam int unsigned PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int unsigned AW = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CW = AW + 1;

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] win;
  logic          found;
  logic          or_free;
  logic          cap_ok;
  logic          grant;
  logic          pop;
  int unsigned   idx;

  logic [PW-1:0] fifo_q [MAX_OUTSTANDING];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Winner search: rotating start in round-robin mode, index 0 first otherwise
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      idx = (ARB_MODE == 1) ? i : (32'(rr_ptr) + i) % N_PORTS;
      if (!found && up_req_valid[PW'(idx)]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  // A response in the same cycle frees a slot, so a full FIFO can still accept a push
  assign or_free = !mem_req_valid || mem_req_ready;
  assign cap_ok  = (outstanding < CW'(MAX_OUTSTANDING)) || mem_resp_valid;
  assign grant   = !rst && found && or_free && cap_ok;
  assign pop     = !rst && mem_resp_valid && (outstanding != '0);

  always_comb begin
    up_req_ready  = '0;
    up_resp_valid = '0;
    if (grant) up_req_ready[win] = 1'b1;
    if (pop)   up_resp_valid[fifo_q[rd_ptr]] = 1'b1;
  end

  assign up_resp_data = mem_resp_data;

  always_ff @(posedge clk) begin
    if (grant) fifo_q[wr_ptr] <= win;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_len   <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      outstanding   <= '0;
      err_orphan    <= 1'b0;
      rr_ptr        <= '0;
    end else begin
      if (or_free) begin
        mem_req_valid <= grant;
        if (grant) begin
          mem_req_we    <= up_req_we[win];
          mem_req_addr  <= up_req_addr[32'(win) * XLEN +: XLEN];
          mem_req_wdata <= up_req_wdata[32'(win) * XLEN +: XLEN];
          mem_req_len   <= up_req_len[32'(win) * 2 +: 2];
        end
      end
      if (grant) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      outstanding <= outstanding + CW'(grant) - CW'(pop);
      if (mem_resp_valid && (outstanding == '0)) err_orphan <= 1'b1;
      if ((ARB_MODE == 0) && grant)
        rr_ptr <= (win == PW'(N_PORTS - 1)) ? '0 : win + PW'(1);
    end
  end

endmodule
